// File: rtl/spi_xfer_ctrl.sv
// spi_xfer_ctrl: transfer sequencer for the spi_clgen SPI master clock generator.
// Accepts a start request, drives enable/go/last_clk, counts SCLK falling edges,
// and frames the transfer with slave-select plus busy/done/abort status.
// Optional macro SPI_CS_GUARD_EN adds guard_i and the SETUP/HOLD guard states
// around the transfer; without it SS simply follows busy.
module spi_xfer_ctrl #(
  parameter int unsigned CHAR_LEN_W = 7
`ifdef SPI_CS_GUARD_EN
  , parameter int unsigned GUARD_W = 4
`endif
) (
  input  logic                  clk_in,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [CHAR_LEN_W-1:0] char_len_i,
`ifdef SPI_CS_GUARD_EN
  input  logic [GUARD_W-1:0]    guard_i,
`endif
  input  logic                  neg_edge_i,
  output logic                  enable_o,
  output logic                  go_o,
  output logic                  last_clk_o,
  output logic                  ss_active_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  aborted_o,
  output logic [CHAR_LEN_W:0]   bit_cnt_o
);

  localparam int unsigned CNT_W = CHAR_LEN_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    XFER  = 2'd2,
    HOLD  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic             go_q, go_d;
  logic             done_q, done_d;
  logic             aborted_q, aborted_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
`ifdef SPI_CS_GUARD_EN
  logic [GUARD_W-1:0] guard_q, guard_d;
  logic [GUARD_W-1:0] gcnt_q, gcnt_d;
`endif

  logic start_ok;
  logic last_edge;

  // A start is accepted only in IDLE and only when no abort accompanies it.
  assign start_ok  = (state_q == IDLE) && start_i && !abort_i;
  // Falling edge that completes the final bit.
  assign last_edge = neg_edge_i && (rem_q == CNT_W'(1));

  // State and status-pulse register.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q   <= IDLE;
      go_q      <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      go_q      <= go_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

  // Next-state logic, including the one-cycle go/done/aborted pulses.
  always_comb begin
    state_d   = state_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_ok) begin
`ifdef SPI_CS_GUARD_EN
          state_d = (guard_i == '0) ? XFER : SETUP;
`else
          state_d = XFER;
`endif
        end
      end
`ifdef SPI_CS_GUARD_EN
      SETUP: begin
        if (abort_i) begin
          state_d   = IDLE;
          aborted_d = 1'b1;
        end else if (gcnt_q == GUARD_W'(1)) begin
          state_d = XFER;
        end
      end
      HOLD: begin
        if (abort_i) begin
          state_d   = IDLE;
          aborted_d = 1'b1;
        end else if (gcnt_q == GUARD_W'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
`endif
      XFER: begin
        if (abort_i) begin
          state_d   = IDLE;
          aborted_d = 1'b1;
        end else if (last_edge) begin
`ifdef SPI_CS_GUARD_EN
          if (guard_q != '0) begin
            state_d = HOLD;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
`else
          state_d = IDLE;
          done_d  = 1'b1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
    go_d = (state_d == XFER) && (state_q != XFER);
  end

  // Output decode from the registered state and counters.
  always_comb begin
    enable_o    = 1'b0;
    busy_o      = 1'b0;
    ss_active_o = 1'b0;
    last_clk_o  = 1'b0;
    enable_o    = (state_q == XFER);
    busy_o      = (state_q != IDLE);
    ss_active_o = (state_q != IDLE);
    last_clk_o  = (state_q == XFER) && (rem_q == CNT_W'(1));
    go_o        = go_q;
    done_o      = done_q;
    aborted_o   = aborted_q;
    bit_cnt_o   = bit_cnt_q;
  end

  // Datapath next values: remaining bits, completed bits and guard counter.
  always_comb begin
    rem_d     = rem_q;
    bit_cnt_d = bit_cnt_q;
`ifdef SPI_CS_GUARD_EN
    guard_d   = guard_q;
    gcnt_d    = gcnt_q;
`endif
    if (start_ok) begin
      rem_d     = (char_len_i == '0) ? (CNT_W'(1) << CHAR_LEN_W) : CNT_W'(char_len_i);
      bit_cnt_d = '0;
`ifdef SPI_CS_GUARD_EN
      guard_d   = guard_i;
      gcnt_d    = guard_i;
`endif
    end else if ((state_q != IDLE) && !abort_i) begin
      if ((state_q == XFER) && neg_edge_i) begin
        rem_d     = rem_q - CNT_W'(1);
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
      end
`ifdef SPI_CS_GUARD_EN
      // Guard counter reloads throughout XFER so HOLD starts from the full count.
      if (state_q == XFER) begin
        gcnt_d = guard_q;
      end else begin
        gcnt_d = gcnt_q - GUARD_W'(1);
      end
`endif
    end
  end

  // Datapath register.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      rem_q     <= '0;
      bit_cnt_q <= '0;
`ifdef SPI_CS_GUARD_EN
      guard_q   <= '0;
      gcnt_q    <= '0;
`endif
    end else begin
      rem_q     <= rem_d;
      bit_cnt_q <= bit_cnt_d;
`ifdef SPI_CS_GUARD_EN
      guard_q   <= guard_d;
      gcnt_q    <= gcnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Testbench for spi_xfer_ctrl: table-driven vectors plus directed multi-cycle
// sequences (full-length transfer, abort, reset mid-transfer, guard framing
// when SPI_CS_GUARD_EN is defined).
module tb_spi_xfer_ctrl;

  localparam int unsigned CLW = 7;

  logic           clk_in = 1'b0;
  logic           rst = 1'b1;
  logic           start_i = 1'b0;
  logic           abort_i = 1'b0;
  logic [CLW-1:0] char_len_i = '0;
  logic           neg_edge_i = 1'b0;
`ifdef SPI_CS_GUARD_EN
  logic [3:0]     guard_i = '0;
`endif
  logic           enable_o, go_o, last_clk_o, ss_active_o, busy_o, done_o, aborted_o;
  logic [CLW:0]   bit_cnt_o;

  int errors = 0;
  int checks = 0;

  spi_xfer_ctrl #(.CHAR_LEN_W(CLW)) dut (
    .clk_in      (clk_in),
    .rst         (rst),
    .start_i     (start_i),
    .abort_i     (abort_i),
    .char_len_i  (char_len_i),
`ifdef SPI_CS_GUARD_EN
    .guard_i     (guard_i),
`endif
    .neg_edge_i  (neg_edge_i),
    .enable_o    (enable_o),
    .go_o        (go_o),
    .last_clk_o  (last_clk_o),
    .ss_active_o (ss_active_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .aborted_o   (aborted_o),
    .bit_cnt_o   (bit_cnt_o)
  );

  always #5 clk_in = ~clk_in;

  // Row: inputs applied for one clock, then expected outputs after that clock.
  // flags order: enable, go, last_clk, ss_active, busy, done, aborted
  typedef struct {
    logic           r;
    logic           s;
    logic           a;
    logic [CLW-1:0] len;
    logic           ne;
    logic [6:0]     flags;
    logic [7:0]     cnt;
  } vec_t;

  vec_t tbl[21];

  function automatic vec_t mk(input logic r, input logic s, input logic a,
                              input logic [CLW-1:0] len, input logic ne,
                              input logic [6:0] flags, input logic [7:0] cnt);
    vec_t v;
    v.r = r; v.s = s; v.a = a; v.len = len; v.ne = ne; v.flags = flags; v.cnt = cnt;
    return v;
  endfunction

  function automatic logic [14:0] obs();
    return {enable_o, go_o, last_clk_o, ss_active_o, busy_o, done_o, aborted_o, bit_cnt_o};
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // Drive inputs for one clock, then leave them idle just after the edge.
  task automatic cyc(input logic r, input logic s, input logic a,
                     input logic [CLW-1:0] len, input logic ne);
    rst = r; start_i = s; abort_i = a; char_len_i = len; neg_edge_i = ne;
    @(posedge clk_in);
    #1;
    rst = 1'b0; start_i = 1'b0; abort_i = 1'b0; neg_edge_i = 1'b0;
  endtask

  initial begin
    logic lc_ok;
    int   done_cnt;

    // 8-bit transfer with an ignored mid-transfer start, then a back-to-back
    // 2-bit transfer started in the done cycle, then idle-time corner cases.
    tbl[0]  = mk(1, 0, 0, 7'd0, 0, 7'b0000000, 8'd0);
    tbl[1]  = mk(0, 0, 0, 7'd0, 0, 7'b0000000, 8'd0);
    tbl[2]  = mk(0, 1, 0, 7'd8, 0, 7'b1101100, 8'd0);
    tbl[3]  = mk(0, 0, 0, 7'd0, 0, 7'b1001100, 8'd0);
    tbl[4]  = mk(0, 0, 0, 7'd0, 1, 7'b1001100, 8'd1);
    tbl[5]  = mk(0, 0, 0, 7'd0, 0, 7'b1001100, 8'd1);
    tbl[6]  = mk(0, 0, 0, 7'd0, 1, 7'b1001100, 8'd2);
    tbl[7]  = mk(0, 1, 0, 7'd3, 0, 7'b1001100, 8'd2);
    tbl[8]  = mk(0, 0, 0, 7'd0, 1, 7'b1001100, 8'd3);
    tbl[9]  = mk(0, 0, 0, 7'd0, 1, 7'b1001100, 8'd4);
    tbl[10] = mk(0, 0, 0, 7'd0, 1, 7'b1001100, 8'd5);
    tbl[11] = mk(0, 0, 0, 7'd0, 1, 7'b1001100, 8'd6);
    tbl[12] = mk(0, 0, 0, 7'd0, 1, 7'b1011100, 8'd7);
    tbl[13] = mk(0, 0, 0, 7'd0, 0, 7'b1011100, 8'd7);
    tbl[14] = mk(0, 0, 0, 7'd0, 1, 7'b0000010, 8'd8);
    tbl[15] = mk(0, 1, 0, 7'd2, 0, 7'b1101100, 8'd0);
    tbl[16] = mk(0, 0, 0, 7'd0, 1, 7'b1011100, 8'd1);
    tbl[17] = mk(0, 0, 0, 7'd0, 1, 7'b0000010, 8'd2);
    tbl[18] = mk(0, 0, 0, 7'd0, 1, 7'b0000000, 8'd2);
    tbl[19] = mk(0, 1, 1, 7'd5, 0, 7'b0000000, 8'd2);
    tbl[20] = mk(0, 0, 0, 7'd0, 0, 7'b0000000, 8'd2);

    @(negedge clk_in);
    for (int i = 0; i < 21; i++) begin
      cyc(tbl[i].r, tbl[i].s, tbl[i].a, tbl[i].len, tbl[i].ne);
      chk($sformatf("vec%0d", i), 32'(obs()), 32'({tbl[i].flags, tbl[i].cnt}));
    end

    // char_len 0 -> 128 bits, last_clk only during the final bit, single done.
    cyc(0, 1, 0, 7'd0, 0);
    chk("len0_go", 32'({enable_o, go_o, last_clk_o}), 32'(3'b110));
    lc_ok = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 128; i++) begin
      if (enable_o !== 1'b1 || last_clk_o !== (i == 127)) lc_ok = 1'b0;
      cyc(0, 0, 0, 7'd0, 1);
      if (done_o === 1'b1) done_cnt++;
    end
    chk("len0_lastclk", 32'(lc_ok), 32'd1);
    chk("len0_end", 32'(obs()), 32'({7'b0000010, 8'd128}));
    cyc(0, 0, 0, 7'd0, 0);
    if (done_o === 1'b1) done_cnt++;
    chk("len0_done_cnt", 32'(done_cnt), 32'd1);

    // Abort after 3 of 8 bits.
    cyc(0, 1, 0, 7'd8, 0);
    cyc(0, 0, 0, 7'd0, 1);
    cyc(0, 0, 0, 7'd0, 1);
    cyc(0, 0, 0, 7'd0, 1);
    cyc(0, 0, 0, 7'd0, 0);
    chk("abort_pre", 32'(obs()), 32'({7'b1001100, 8'd3}));
    cyc(0, 0, 1, 7'd0, 0);
    chk("abort_pulse", 32'(obs()), 32'({7'b0000001, 8'd3}));
    cyc(0, 0, 0, 7'd0, 0);
    chk("abort_after", 32'(obs()), 32'({7'b0000000, 8'd3}));

    // Reset in XFER, then a fresh 1-bit transfer.
    cyc(0, 1, 0, 7'd8, 0);
    cyc(0, 0, 0, 7'd0, 1);
    cyc(0, 0, 0, 7'd0, 1);
    cyc(1, 0, 0, 7'd0, 1);
    chk("rst_mid", 32'(obs()), 32'({7'b0000000, 8'd0}));
    cyc(0, 0, 0, 7'd0, 0);
    chk("rst_quiet", 32'(obs()), 32'({7'b0000000, 8'd0}));
    cyc(0, 1, 0, 7'd1, 0);
    chk("rst_restart", 32'(obs()), 32'({7'b1111100, 8'd0}));
    cyc(0, 0, 0, 7'd0, 1);
    chk("rst_done", 32'(obs()), 32'({7'b0000010, 8'd1}));

`ifdef SPI_CS_GUARD_EN
    // Guard of 3 cycles around a 4-bit transfer.
    guard_i = 4'd3;
    cyc(0, 1, 0, 7'd4, 0);
    guard_i = 4'd0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("grd_setup%0d", k), 32'(obs()), 32'({7'b0001100, 8'd0}));
      cyc(0, 0, 0, 7'd0, 0);
    end
    chk("grd_go", 32'(obs()), 32'({7'b1101100, 8'd0}));
    for (int k = 0; k < 4; k++) cyc(0, 0, 0, 7'd0, 1);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("grd_hold%0d", k), 32'(obs()), 32'({7'b0001100, 8'd4}));
      cyc(0, 0, 0, 7'd0, 0);
    end
    chk("grd_done", 32'(obs()), 32'({7'b0000010, 8'd4}));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
